// File: rtl/mlaccel_qpi_slave_if.sv
// QPI responder bus bundle: host pins, pad-side outputs, rx/tx byte streams.
// slave: the responder; master: host pins and the byte consumer/producer.
interface mlaccel_qpi_slave_if;
    logic       qpi_csb;
    logic       qpi_clk;
    logic [3:0] qpi_di;
    logic [3:0] qpi_do;
    logic       qpi_oe;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_start;
    logic       tx_enable;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       xfer_active;
    logic       xfer_end;

    modport slave (
        input  qpi_csb, qpi_clk, qpi_di,
        input  tx_enable, tx_valid, tx_data,
        output qpi_do, qpi_oe,
        output rx_valid, rx_data, rx_start,
        output tx_ready, xfer_active, xfer_end
    );

    modport master (
        output qpi_csb, qpi_clk, qpi_di,
        output tx_enable, tx_valid, tx_data,
        input  qpi_do, qpi_oe,
        input  rx_valid, rx_data, rx_start,
        input  tx_ready, xfer_active, xfer_end
    );
endinterface

// File: rtl/mlaccel_qpi_slave.sv
// QPI device-side responder: oversamples host pins, deserialises nibbles
// to bytes, and serialises tx bytes after a one-byte turnaround.
// Ports: clock, resetn (async, active low), bus (mlaccel_qpi_slave_if.slave).
module mlaccel_qpi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h01
) (
    input  logic                  clock,
    input  logic                  resetn,
    mlaccel_qpi_slave_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_RX,
        ST_TURN,
        ST_TX
    } state_t;

    logic [SYNC_STAGES-1:0]       csb_sync_q;
    logic [SYNC_STAGES-1:0]       clk_sync_q;
    logic [SYNC_STAGES-1:0][3:0]  di_sync_q;

    logic       csb_s;
    logic       clk_s;
    logic [3:0] di_s;

    state_t     state_q;
    logic       nib_q;
    logic       first_q;
    logic [3:0] hi_q;
    logic [3:0] lo_q;
    logic [3:0] do_q;
    logic       rx_valid_q;
    logic [7:0] rx_data_q;
    logic       rx_start_q;
    logic       tx_ready_q;
    logic       act_q;
    logic       end_q;
    logic       csb_prev_q;
    logic       clk_prev_q;

    logic       clk_rise;
    logic       csb_rise;
    logic [7:0] load_byte;

    // Data is synchronised through the same depth as the clock so the
    // sampled nibble lines up with the detected edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            csb_sync_q <= '1;
            clk_sync_q <= '0;
            di_sync_q  <= '0;
        end else begin
            csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], bus.qpi_csb};
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], bus.qpi_clk};
            di_sync_q  <= {di_sync_q[SYNC_STAGES-2:0], bus.qpi_di};
        end
    end

    assign csb_s = csb_sync_q[SYNC_STAGES-1];
    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign di_s  = di_sync_q[SYNC_STAGES-1];

    assign clk_rise  = clk_s & ~clk_prev_q & ~csb_s;
    assign csb_rise  = csb_s & ~csb_prev_q;
    assign load_byte = bus.tx_valid ? bus.tx_data : IDLE_BYTE;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_RX;
            nib_q      <= 1'b0;
            first_q    <= 1'b1;
            hi_q       <= '0;
            lo_q       <= '0;
            do_q       <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_start_q <= 1'b0;
            tx_ready_q <= 1'b0;
            act_q      <= 1'b0;
            end_q      <= 1'b0;
            csb_prev_q <= 1'b1;
            clk_prev_q <= 1'b0;
        end else begin
            clk_prev_q <= clk_s;
            csb_prev_q <= csb_s;
            act_q      <= ~csb_s;
            end_q      <= csb_rise;
            rx_valid_q <= 1'b0;
            rx_start_q <= 1'b0;
            tx_ready_q <= 1'b0;
            // csb rise takes priority over a coincident clock edge.
            if (csb_rise) begin
                state_q <= ST_RX;
                nib_q   <= 1'b0;
                first_q <= 1'b1;
                do_q    <= '0;
            end else if (clk_rise) begin
                unique case (state_q)
                    ST_RX: begin
                        if (!nib_q) begin
                            if (bus.tx_enable) begin
                                state_q <= ST_TURN;
                            end else begin
                                hi_q  <= di_s;
                                nib_q <= 1'b1;
                            end
                        end else begin
                            rx_data_q  <= {hi_q, di_s};
                            rx_valid_q <= 1'b1;
                            rx_start_q <= first_q;
                            first_q    <= 1'b0;
                            nib_q      <= 1'b0;
                        end
                    end
                    ST_TURN: begin
                        state_q    <= ST_TX;
                        nib_q      <= 1'b0;
                        do_q       <= load_byte[7:4];
                        lo_q       <= load_byte[3:0];
                        tx_ready_q <= bus.tx_valid;
                    end
                    ST_TX: begin
                        if (!nib_q) begin
                            do_q  <= lo_q;
                            nib_q <= 1'b1;
                        end else begin
                            do_q       <= load_byte[7:4];
                            lo_q       <= load_byte[3:0];
                            tx_ready_q <= bus.tx_valid;
                            nib_q      <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_RX;
                        nib_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.qpi_oe      = (state_q == ST_TX);
    assign bus.qpi_do      = do_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_start    = rx_start_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.xfer_active = act_q;
    assign bus.xfer_end    = end_q;

endmodule
